k12a_lcd_sequencer: RTL and testbench
=====================================

Name: k12a_lcd_sequencer

Overview:
- Timed write sequencer for an HD44780-style character LCD on the k12a IO subsystem.
- The CPU writes command/data bytes through an IO store strobe; bytes are buffered in a small FIFO.
- Each byte is played out with programmable setup, enable-pulse, hold and post-command delays, so software never busy-waits on LCD timing.
- Replaces the single-cycle lcd_en gating in the IO block; its status outputs are readable through the IO control register.

Parameters:
- FIFO_DEPTH, 4: entries in the write FIFO; power of two, minimum 2.
- SETUP_CYCLES, 1: cycles lcd_rs/lcd_data are stable before lcd_en rises; minimum 1.
- EN_CYCLES, 4: lcd_en high width in cycles; minimum 1.
- HOLD_CYCLES, 1: cycles lcd_rs/lcd_data are held after lcd_en falls; minimum 1.
- CMD_DELAY, 40: idle cycles after a normal transfer; minimum 1.
- LONG_DELAY, 1600: idle cycles after clear/home (rs=0, byte 0x01, 0x02 or 0x03); minimum 1.

Ports:
- cpu_clock, input, 1: system clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- wr_n, input, 1: active-low write strobe, sampled on the rising edge.
- wr_rs, input, 1: register select for the write; 0 = instruction, 1 = data.
- wr_data, input, 8: byte to enqueue.
- fifo_full, output, 1: FIFO holds FIFO_DEPTH entries.
- busy, output, 1: high while the FIFO is non-empty or the FSM is not IDLE.
- overflow, output, 1: sticky; a write arrived while the FIFO was full.
- lcd_rs, output, 1: LCD register select.
- lcd_rw, output, 1: LCD read/write; tied to 0 (write only).
- lcd_en, output, 1: LCD enable strobe; registered, glitch-free.
- lcd_data, output, 8: LCD data bus.

Behaviour:
- Reset values:
  - lcd_en=0, lcd_rs=0, lcd_data=0x00, lcd_rw=0.
  - FIFO empty, fifo_full=0, busy=0, overflow=0, FSM in IDLE.
  - Asserting reset mid-transfer aborts it immediately: lcd_en drops asynchronously and all queued entries are discarded.
- Enqueue:
  - An edge with wr_n=0 and fifo_full=0 pushes {wr_rs, wr_data}.
  - An edge with wr_n=0 and fifo_full=1 drops the byte and sets overflow; overflow clears only on reset.
  - fullness is evaluated before any same-edge pop, so a write that coincides with a pop from a full FIFO is still dropped.
- Each cycle wr_n is low counts as a separate write, so software must hold wr_n low for exactly one cycle per byte.
- FIFO pointers wrap modulo FIFO_DEPTH; the count is tracked separately so full and empty are unambiguous.
- FSM states: IDLE, SETUP, ENABLE, HOLD, DELAY. A single down-counter is reloaded on each transition.
  - IDLE: if the FIFO is non-empty, pop the head into the lcd_rs/lcd_data registers, load SETUP_CYCLES, go to SETUP. Otherwise stay.
  - SETUP: lcd_en=0. When the counter reaches 1, load EN_CYCLES and go to ENABLE.
  - ENABLE: lcd_en=1. When the counter reaches 1, load HOLD_CYCLES and go to HOLD.
  - HOLD: lcd_en=0. When the counter reaches 1, load LONG_DELAY if the transfer was rs=0 with byte 0x01–0x03, otherwise CMD_DELAY; go to DELAY.
  - DELAY: when the counter reaches 1, go to IDLE.
- lcd_rs and lcd_data keep their last values until the next pop.
- Latency:
  - A write accepted at edge N produces lcd_data/lcd_rs valid after edge N+1.
  - lcd_en rises after edge N+1+SETUP_CYCLES and is high for exactly EN_CYCLES cycles.
  - Back-to-back transfers: the next pop happens 1 cycle after DELAY ends (IDLE occupies one cycle).
- A write arriving while the FIFO is empty and the FSM is in DELAY is queued and waits; the delay is never shortened.
- busy = (FSM != IDLE) | (FIFO non-empty); it is also high in the cycle immediately after a push into an empty FIFO.

Optional Feature:
- Macro: K12A_LCD_4BIT_EN.
- Defined (4-bit mode):
  - Each byte is sent as two nibbles on lcd_data[7:4], high nibble first; lcd_data[3:0] is driven to 0.
  - After the HOLD of the high nibble, the FSM loads the low nibble and returns to SETUP with no DELAY.
  - DELAY (and the LONG_DELAY decision, based on the full byte) applies only after the low nibble.
  - Each byte produces two lcd_en pulses.
- Undefined (8-bit mode, default): one pulse per byte on lcd_data[7:0], with no nibble logic synthesized.

Test Plan:
- Reset, then a single write of rs=1, data=0x41 with defaults:
  - lcd_data=0x41 and lcd_rs=1 one cycle after the write.
  - lcd_en high for exactly 4 cycles, starting 2 cycles after the write edge.
  - busy stays high for 1+1+4+1+40 cycles, then falls.
- Write rs=0, data=0x01 (clear): DELAY lasts 1600 cycles. A second write of 0x80 issued during that delay does not pulse lcd_en until the delay ends.
- Five back-to-back single-cycle writes (0x10–0x14) with FIFO_DEPTH=4:
  - fifo_full asserts after the 4th write; overflow=1 after the 5th.
  - Exactly 4 lcd_en pulses occur, carrying 0x10–0x13 in order.
- FIFO pointer wrap: write 3 bytes, let them drain, then write 4 bytes. All 7 bytes appear in order and fifo_full asserts only on the 4th of the second batch.
- Reset mid-transfer: assert reset_n=0 while lcd_en=1.
  - lcd_en drops immediately; busy=0 and overflow=0.
  - Queued bytes never appear after release.
- With K12A_LCD_4BIT_EN defined, write rs=1, data=0xA5:
  - Two lcd_en pulses with lcd_data=0xA0 then 0x50, separated by HOLD+SETUP cycles.
  - CMD_DELAY is applied only after the second pulse.

Source files
------------

// File: rtl/k12a_lcd_sequencer.sv
// rtl/k12a_lcd_sequencer.sv - timed HD44780 write sequencer with write FIFO (4-bit mode: K12A_LCD_4BIT_EN)
module k12a_lcd_sequencer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int EN_CYCLES    = 4,
  parameter int HOLD_CYCLES  = 1,
  parameter int CMD_DELAY    = 40,
  parameter int LONG_DELAY   = 1600
) (
  input  logic       cpu_clock,
  input  logic       reset_n,
  input  logic       wr_n,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       fifo_full,
  output logic       busy,
  output logic       overflow,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int MAX_A = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int MAX_B = (HOLD_CYCLES > CMD_DELAY) ? HOLD_CYCLES : CMD_DELAY;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_D = (MAX_C > LONG_DELAY) ? MAX_C : LONG_DELAY;
  localparam int CW    = $clog2(MAX_D + 1);

  localparam logic [CW-1:0] C_ONE   = CW'(1);
  localparam logic [CW-1:0] C_SETUP = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] C_EN    = CW'(EN_CYCLES);
  localparam logic [CW-1:0] C_HOLD  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] C_CMD   = CW'(CMD_DELAY);
  localparam logic [CW-1:0] C_LONG  = CW'(LONG_DELAY);
  localparam logic [PW:0]   C_FULL  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ENABLE, S_HOLD, S_DELAY} state_t;

  logic [8:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_en;
  logic          r_rs;
  logic [7:0]    r_byte;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_long;
  logic [8:0]    w_head;

`ifdef K12A_LCD_4BIT_EN
  logic          r_lo;
  logic          w_lo_set;
`endif

  assign w_full = (r_count == C_FULL);
  assign w_push = !wr_n && !w_full;
  assign w_head = r_mem[r_rd_ptr];
  assign w_long = !r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));

  // FIFO storage; contents need no reset because pointers and count define validity
  always_ff @(posedge cpu_clock) begin
    if (w_push) r_mem[r_wr_ptr] <= {wr_rs, wr_data};
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (!wr_n && w_full) r_overflow <= 1'b1;
    end
  end

  // Next-state logic: one down-counter reloaded on every state change
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pop       = 1'b0;
`ifdef K12A_LCD_4BIT_EN
    w_lo_set    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
          w_cnt_nxt   = C_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == C_ONE) begin
          w_state_nxt = S_ENABLE;
          w_cnt_nxt   = C_EN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ENABLE: begin
        if (r_cnt == C_ONE) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = C_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == C_ONE) begin
`ifdef K12A_LCD_4BIT_EN
          if (!r_lo) begin
            w_state_nxt = S_SETUP;
            w_cnt_nxt   = C_SETUP;
            w_lo_set    = 1'b1;
          end else
`endif
          begin
            w_state_nxt = S_DELAY;
            w_cnt_nxt   = w_long ? C_LONG : C_CMD;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_DELAY: begin
        if (r_cnt == C_ONE) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register; lcd_en is registered from the next state so it never glitches
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_en    <= (w_state_nxt == S_ENABLE);
    end
  end

  // Transfer registers: captured on pop and held until the next pop
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rs   <= 1'b0;
      r_byte <= 8'h00;
`ifdef K12A_LCD_4BIT_EN
      r_lo   <= 1'b0;
`endif
    end else begin
      if (w_pop) {r_rs, r_byte} <= w_head;
`ifdef K12A_LCD_4BIT_EN
      if (w_pop)         r_lo <= 1'b0;
      else if (w_lo_set) r_lo <= 1'b1;
`endif
    end
  end

`ifdef K12A_LCD_4BIT_EN
  assign lcd_data = r_lo ? {r_byte[3:0], 4'h0} : {r_byte[7:4], 4'h0};
`else
  assign lcd_data = r_byte;
`endif

  assign lcd_rs    = r_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_en    = r_en;
  assign fifo_full = w_full;
  assign overflow  = r_overflow;
  assign busy      = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_k12a_lcd_sequencer.sv
// tb/tb_k12a_lcd_sequencer.sv - scoreboard bench for k12a_lcd_sequencer
module tb_k12a_lcd_sequencer;

`ifdef K12A_LCD_4BIT_EN
  localparam int PPB       = 2;
  localparam int BUSY_41   = 53;
  localparam int CLR_RISE  = 1615;
  localparam logic [7:0] FIRST_41 = 8'h40;
`else
  localparam int PPB       = 1;
  localparam int BUSY_41   = 47;
  localparam int CLR_RISE  = 1609;
  localparam logic [7:0] FIRST_41 = 8'h41;
`endif

  logic       cpu_clock;
  logic       reset_n;
  logic       wr_n;
  logic       wr_rs;
  logic [7:0] wr_data;
  logic       fifo_full;
  logic       busy;
  logic       overflow;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  logic [8:0] exp_q [$];
  int rise_log [$];

  k12a_lcd_sequencer dut (
    .cpu_clock (cpu_clock),
    .reset_n   (reset_n),
    .wr_n      (wr_n),
    .wr_rs     (wr_rs),
    .wr_data   (wr_data),
    .fifo_full (fifo_full),
    .busy      (busy),
    .overflow  (overflow),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_en    (lcd_en),
    .lcd_data  (lcd_data)
  );

  initial begin
    cpu_clock = 1'b0;
    forever #5 cpu_clock = ~cpu_clock;
  end

  always @(posedge cpu_clock) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic rs, input logic [7:0] d);
`ifdef K12A_LCD_4BIT_EN
    exp_q.push_back({rs, d[7:4], 4'h0});
    exp_q.push_back({rs, d[3:0], 4'h0});
`else
    exp_q.push_back({rs, d});
`endif
  endtask

  // call at a negedge; returns at the negedge after the write edge
  task automatic wr(input logic rs, input logic [7:0] d);
    wr_n    = 1'b0;
    wr_rs   = rs;
    wr_data = d;
    @(negedge cpu_clock);
    wr_n    = 1'b1;
    wr_cyc  = cyc;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      @(negedge cpu_clock);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Monitor: every lcd_en pulse pops the scoreboard and is checked for content and width
  logic       m_prev = 1'b0;
  int         m_hi   = 0;
  logic [8:0] m_cap  = '0;
  always @(negedge cpu_clock) begin
    if (!reset_n) begin
      m_prev = 1'b0;
      m_hi   = 0;
    end else begin
      if (lcd_en && !m_prev) begin
        rise_log.push_back(cyc);
        m_cap = {lcd_rs, lcd_data};
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {23'd0, m_cap}, 32'h1ff);
        end else begin
          chk("pulse_data", {23'd0, m_cap}, {23'd0, exp_q.pop_front()});
        end
        chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
      end
      if (lcd_en) m_hi++;
      if (!lcd_en && m_prev) begin
        chk("en_width", m_hi, 32'd4);
        chk("data_stable", {23'd0, lcd_rs, lcd_data}, {23'd0, m_cap});
        m_hi = 0;
      end
      m_prev = lcd_en;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int a;
    int bcnt;
    int n;
    reset_n = 1'b0;
    wr_n    = 1'b1;
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge cpu_clock);
    reset_n = 1'b1;
    @(negedge cpu_clock);

    // reset state
    chk("rst_lcd_en",   {31'd0, lcd_en},    32'd0);
    chk("rst_lcd_rs",   {31'd0, lcd_rs},    32'd0);
    chk("rst_lcd_data", {24'd0, lcd_data},  32'd0);
    chk("rst_lcd_rw",   {31'd0, lcd_rw},    32'd0);
    chk("rst_full",     {31'd0, fifo_full}, 32'd0);
    chk("rst_busy",     {31'd0, busy},      32'd0);
    chk("rst_overflow", {31'd0, overflow},  32'd0);

    // single data write: latency, pulse position and busy length
    expect_byte(1'b1, 8'h41);
    wr(1'b1, 8'h41);
    a = wr_cyc;
    bcnt = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1) begin
        chk("lat_data", {24'd0, lcd_data}, {24'd0, FIRST_41});
        chk("lat_rs",   {31'd0, lcd_rs},   32'd1);
        chk("lat_en_lo", {31'd0, lcd_en},  32'd0);
      end
      if (i == 2) chk("lat_en_hi", {31'd0, lcd_en}, 32'd1);
      if (!busy) break;
      bcnt++;
      @(negedge cpu_clock);
    end
    chk("busy_len", bcnt, BUSY_41);
    chk("rise_pos", rise_log[0] - a, 32'd2);

    // clear command: a write during the long delay waits for it to end
    base = rise_log.size();
    expect_byte(1'b0, 8'h01);
    wr(1'b0, 8'h01);
    a = wr_cyc;
    repeat (20) @(negedge cpu_clock);
    expect_byte(1'b0, 8'h80);
    wr(1'b0, 8'h80);
    wait_idle(5000);
    if (rise_log.size() > base + PPB) chk("long_delay", rise_log[base + PPB] - a, CLR_RISE);
    else chk("long_delay_pulses", rise_log.size() - base, 2 * PPB);

    // overflow: five writes while the FSM is busy with a previous transfer
    base = rise_log.size();
    expect_byte(1'b1, 8'h0f);
    wr(1'b1, 8'h0f);
    repeat (20) @(negedge cpu_clock);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) expect_byte(1'b1, 8'(8'h10 + k));
      wr(1'b1, 8'(8'h10 + k));
      chk($sformatf("ovf_full_%0d", k), {31'd0, fifo_full}, (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_flag_%0d", k), {31'd0, overflow},  (k == 4) ? 32'd1 : 32'd0);
    end
    wait_idle(20000);
    chk("ovf_pulses", rise_log.size() - base, 5 * PPB);

    // pointer wrap: 3 bytes drained, then 4 queued behind the last delay
    base = rise_log.size();
    for (int k = 0; k < 3; k++) begin
      expect_byte(1'b1, 8'(8'h20 + k));
      wr(1'b1, 8'(8'h20 + k));
    end
    n = 0;
    while (rise_log.size() < base + 3 * PPB && n < 2000) begin
      @(negedge cpu_clock);
      n++;
    end
    chk("wrap_drain", rise_log.size() - base, 3 * PPB);
    repeat (20) @(negedge cpu_clock);
    for (int k = 0; k < 4; k++) begin
      expect_byte(1'b0, 8'(8'h30 + k));
      wr(1'b0, 8'(8'h30 + k));
      chk($sformatf("wrap_full_%0d", k), {31'd0, fifo_full}, (k == 3) ? 32'd1 : 32'd0);
    end
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);
    wait_idle(20000);
    chk("wrap_pulses", rise_log.size() - base, 7 * PPB);

    // reset mid-transfer
    base = rise_log.size();
    for (int k = 0; k < 3; k++) begin
      expect_byte(1'b1, 8'(8'h50 + k));
      wr(1'b1, 8'(8'h50 + k));
    end
    n = 0;
    while (!lcd_en && n < 100) begin
      @(negedge cpu_clock);
      n++;
    end
    chk("rst_wait_en", {31'd0, lcd_en}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_en",   {31'd0, lcd_en},    32'd0);
    chk("abort_busy", {31'd0, busy},      32'd0);
    chk("abort_ovf",  {31'd0, overflow},  32'd0);
    chk("abort_full", {31'd0, fifo_full}, 32'd0);
    exp_q.delete();
    repeat (3) @(negedge cpu_clock);
    reset_n = 1'b1;
    repeat (300) @(negedge cpu_clock);
    chk("abort_no_pulse", rise_log.size() - base, 32'd1);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    // 0xA5 data byte: nibble pulses in 4-bit mode, single pulse otherwise
    base = rise_log.size();
    expect_byte(1'b1, 8'ha5);
    wr(1'b1, 8'ha5);
    wait_idle(2000);
    chk("a5_pulses", rise_log.size() - base, PPB);
`ifdef K12A_LCD_4BIT_EN
    if (rise_log.size() >= base + 2) chk("nibble_gap", rise_log[base + 1] - rise_log[base], 32'd6);
`endif

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
